// File: rtl/grant_dec_pkg.sv
// grant_dec_pkg
//   Shared definitions for the grant decoder sequencer.
//   - gd_state_e : output sequencer state encoding
//   - DEF_IN_WIDTH / OUT_WIDTH : default index width and matching one-hot width
//   - clog2 : ceiling log2, used for pointer and counter widths
package grant_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } gd_state_e;

    localparam int unsigned DEF_IN_WIDTH = 4;
    localparam int unsigned OUT_WIDTH    = 2 ** DEF_IN_WIDTH;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/grant_code_fifo.sv
// grant_code_fifo
//   Synchronous FIFO holding pending grant indices.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous active-high reset, empties the FIFO
//     push   - write din (ignored while full)
//     pop    - advance read pointer (ignored while empty)
//     din    - data written on push
//     dout   - head entry (valid when count != 0)
//     count  - registered occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally; count is
//   the only full/empty indicator.
module grant_code_fifo
    import grant_dec_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q < CW'(DEPTH));
        pop_ok   = pop  && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/grant_decoder_sequencer.sv
// grant_decoder_sequencer
//   Queues binary grant indices and replays each as a one-hot strobe held
//   for DWELL cycles, followed by GAP all-zero cycles and one IDLE cycle.
//   Ports:
//     clk          - rising-edge clock
//     reset        - asynchronous active-high reset (flushes FIFO, clears outputs)
//     enable       - low aborts any in-flight code and stops pops
//     binary_in    - index to queue
//     in_valid     - binary_in valid; accepted when in_ready is high
//     in_ready     - combinational, FIFO occupancy below DEPTH
//     decoder_out  - registered one-hot grant (all zero outside DRIVE)
//     out_busy     - registered, high during DRIVE and GAP
//     fifo_count   - registered FIFO occupancy
module grant_decoder_sequencer
    import grant_dec_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DWELL    = 2,
    parameter int unsigned GAP      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [IN_WIDTH-1:0]       binary_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [(2**IN_WIDTH)-1:0]  decoder_out,
    output logic                      out_busy,
    output logic [clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned DEC_W = 2 ** IN_WIDTH;
    localparam int unsigned CNT_W = clog2(DEPTH) + 1;
    localparam int unsigned DW_W  = clog2(DWELL + 1);
    localparam int unsigned GP_W  = clog2(GAP + 1);

    gd_state_e        state_q, state_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [GP_W-1:0]  gap_q,   gap_d;
    logic [DEC_W-1:0] dec_q,   dec_d;
    logic             busy_q,  busy_d;

    logic                push;
    logic                pop;
    logic [IN_WIDTH-1:0] head;
    logic [CNT_W-1:0]    count;

    // Readiness uses only the registered count: a full FIFO refuses a push
    // even in a cycle where the sequencer pops.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    grant_code_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (binary_in),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        dec_d   = dec_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dec_d = '0;
                if (enable && (count != '0)) begin
                    pop     = 1'b1;
                    dec_d   = DEC_W'(1) << head;
                    dwell_d = DW_W'(DWELL - 1);
                    busy_d  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    // In-flight code is dropped, not re-queued.
                    dec_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (dwell_q == '0) begin
                    dec_d   = '0;
                    gap_d   = GP_W'(GAP - 1);
                    state_d = ST_GAP;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            ST_GAP: begin
                dec_d = '0;
                if (!enable || (gap_q == '0)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                dec_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            gap_q   <= '0;
            dec_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
        end
    end

    assign decoder_out = dec_q;
    assign out_busy    = busy_q;
    assign fifo_count  = count;

endmodule
